// File: rtl/sal_bank_ctrl_pkg.sv
// Shared DRAM/AXI types, bank FSM encoding and default per-bank timing values.
package sal_bank_ctrl_pkg;

  localparam int unsigned DRAM_BK_CNT = 8;
  localparam int unsigned DRAM_RA_W   = 16;
  localparam int unsigned DRAM_CA_W   = 10;
  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_LEN_W   = 8;

  typedef logic [DRAM_RA_W-1:0] dram_ra_t;
  typedef logic [DRAM_CA_W-1:0] dram_ca_t;
  typedef logic [AXI_ID_W-1:0]  axi_id_t;
  typedef logic [AXI_LEN_W-1:0] axi_len_t;

  // Default timing in controller clock cycles.
  localparam int unsigned T_RCD_DEF = 4;
  localparam int unsigned T_RAS_DEF = 12;
  localparam int unsigned T_RTP_DEF = 3;
  localparam int unsigned T_WTP_DEF = 10;
  localparam int unsigned T_RP_DEF  = 4;
  localparam int unsigned T_RFC_DEF = 43;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    BK_CLOSED  = 2'd0,
    BK_OPEN    = 2'd1,
    BK_REFRESH = 2'd2
  } bk_state_t;

  // One buffered request as seen by the bank.
  typedef struct packed {
    logic     wr;
    dram_ra_t ra;
    dram_ca_t ca;
    axi_id_t  id;
    axi_len_t len;
  } bank_req_t;

endpackage

// File: rtl/sal_bank_ctrl_timer.sv
// Loadable down-counter that saturates at zero; one instance per timing constraint.
module sal_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             is_zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Load has priority over the per-cycle decrement; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank open-page controller: buffers one request, tracks the open row,
// enforces bank timing and raises one command request to the scheduler.
module sal_bank_ctrl
  import sal_bank_ctrl_pkg::*;
#(
  parameter int unsigned T_RCD = T_RCD_DEF,
  parameter int unsigned T_RAS = T_RAS_DEF,
  parameter int unsigned T_RTP = T_RTP_DEF,
  parameter int unsigned T_WTP = T_WTP_DEF,
  parameter int unsigned T_RP  = T_RP_DEF,
  parameter int unsigned T_RFC = T_RFC_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic     req_wr,
  input  dram_ra_t req_ra,
  input  dram_ca_t req_ca,
  input  axi_id_t  req_id,
  input  axi_len_t req_len,
  input  logic     ref_in,
  output logic     ref_done,
  output logic     act_req,
  output logic     rd_req,
  output logic     wr_req,
  output logic     pre_req,
  output logic     ref_req,
  input  logic     act_gnt,
  input  logic     rd_gnt,
  input  logic     wr_gnt,
  input  logic     pre_gnt,
  input  logic     ref_gnt,
  output dram_ra_t ra,
  output dram_ca_t ca,
  output axi_id_t  id,
  output axi_len_t len
);

  localparam logic [CNT_W-1:0] C_RCD = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] C_RAS = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] C_RTP = CNT_W'(T_RTP);
  localparam logic [CNT_W-1:0] C_WTP = CNT_W'(T_WTP);
  localparam logic [CNT_W-1:0] C_RP  = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] C_RFC = CNT_W'(T_RFC);

  bk_state_t  state;
  bank_req_t  lat;
  dram_ra_t   open_row;
  logic       pend_q;
  logic       ref_pend_q;

  logic [CNT_W-1:0] rcd_cnt, ras_cnt, rtw_cnt, rp_cnt, rfc_cnt;
  logic             rcd_zero, ras_zero, rtw_zero, rp_zero, rfc_zero;
  logic [CNT_W-1:0] rtw_load_val;

  logic accept;
  logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
  logic row_hit, need_pre;

  assign req_ready = rst_n & ~pend_q;
  assign accept    = req_valid & req_ready;

  // Grants only take effect when they answer the request currently raised.
  assign act_fire = act_req & act_gnt;
  assign rd_fire  = rd_req  & rd_gnt;
  assign wr_fire  = wr_req  & wr_gnt;
  assign pre_fire = pre_req & pre_gnt;
  assign ref_fire = ref_req & ref_gnt;

  assign row_hit  = pend_q & (lat.ra == open_row);
  assign need_pre = ref_pend_q | (pend_q & (lat.ra != open_row));

  // Command request decode; refresh outranks column commands on a row hit.
  always_comb begin
    act_req  = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    pre_req  = 1'b0;
    ref_req  = 1'b0;
    ref_done = 1'b0;
    unique case (state)
      BK_CLOSED: begin
        if (ref_pend_q) begin
          ref_req = rp_zero;
        end else if (pend_q) begin
          act_req = rp_zero;
        end
      end
      BK_OPEN: begin
        if (need_pre) begin
          pre_req = ras_zero & rtw_zero;
        end else if (row_hit & rcd_zero) begin
          rd_req = ~lat.wr;
          wr_req = lat.wr;
        end
      end
      BK_REFRESH: begin
        ref_done = rfc_zero;
      end
      default: begin
      end
    endcase
  end

  // Read/write-to-precharge keeps the longer of the running and new constraint.
  always_comb begin
    rtw_load_val = '0;
    if (wr_fire) begin
      rtw_load_val = (rtw_cnt > C_WTP) ? rtw_cnt : C_WTP;
    end else if (rd_fire) begin
      rtw_load_val = (rtw_cnt > C_RTP) ? rtw_cnt : C_RTP;
    end
  end

  sal_timer #(.CNT_W(CNT_W)) u_rcd (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(C_RCD),
    .cnt(rcd_cnt), .is_zero(rcd_zero)
  );

  sal_timer #(.CNT_W(CNT_W)) u_ras (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(C_RAS),
    .cnt(ras_cnt), .is_zero(ras_zero)
  );

  sal_timer #(.CNT_W(CNT_W)) u_rtw (
    .clk(clk), .rst_n(rst_n), .load(rd_fire | wr_fire), .load_val(rtw_load_val),
    .cnt(rtw_cnt), .is_zero(rtw_zero)
  );

  sal_timer #(.CNT_W(CNT_W)) u_rp (
    .clk(clk), .rst_n(rst_n), .load(pre_fire), .load_val(C_RP),
    .cnt(rp_cnt), .is_zero(rp_zero)
  );

  sal_timer #(.CNT_W(CNT_W)) u_rfc (
    .clk(clk), .rst_n(rst_n), .load(ref_fire), .load_val(C_RFC),
    .cnt(rfc_cnt), .is_zero(rfc_zero)
  );

  // Bank state, request buffer, open row and refresh-pending tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BK_CLOSED;
      lat        <= '0;
      open_row   <= '0;
      pend_q     <= 1'b0;
      ref_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        lat.wr  <= req_wr;
        lat.ra  <= req_ra;
        lat.ca  <= req_ca;
        lat.id  <= req_id;
        lat.len <= req_len;
        pend_q  <= 1'b1;
      end else if (rd_fire | wr_fire) begin
        pend_q <= 1'b0;
      end

      // A refresh pulse arriving while one is pending merges into it.
      if (ref_fire) begin
        ref_pend_q <= 1'b0;
      end else if (ref_in) begin
        ref_pend_q <= 1'b1;
      end

      unique case (state)
        BK_CLOSED: begin
          if (ref_fire) begin
            state <= BK_REFRESH;
          end else if (act_fire) begin
            state    <= BK_OPEN;
            open_row <= lat.ra;
          end
        end
        BK_OPEN: begin
          if (pre_fire) begin
            state <= BK_CLOSED;
          end
        end
        BK_REFRESH: begin
          if (rfc_zero) begin
            state <= BK_CLOSED;
          end
        end
        default: state <= BK_CLOSED;
      endcase
    end
  end

  assign ra  = lat.ra;
  assign ca  = lat.ca;
  assign id  = lat.id;
  assign len = lat.len;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Scoreboard bench for sal_bank_ctrl: stimulus queues expected command events,
// a negedge monitor pops and checks them as the DUT raises each request.
module tb_sal_bank_ctrl;
  import sal_bank_ctrl_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     req_valid = 1'b0;
  logic     req_ready;
  logic     req_wr = 1'b0;
  dram_ra_t req_ra = '0;
  dram_ca_t req_ca = '0;
  axi_id_t  req_id = '0;
  axi_len_t req_len = '0;
  logic     ref_in = 1'b0;
  logic     ref_done;
  logic     act_req, rd_req, wr_req, pre_req, ref_req;
  logic     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  dram_ra_t ra;
  dram_ca_t ca;
  axi_id_t  id;
  axi_len_t len;

  logic [4:0] gnt = '0;
  assign act_gnt = gnt[0];
  assign rd_gnt  = gnt[1];
  assign wr_gnt  = gnt[2];
  assign pre_gnt = gnt[3];
  assign ref_gnt = gnt[4];

  localparam logic [5:0] EV_ACT  = 6'b000001;
  localparam logic [5:0] EV_RD   = 6'b000010;
  localparam logic [5:0] EV_WR   = 6'b000100;
  localparam logic [5:0] EV_PRE  = 6'b001000;
  localparam logic [5:0] EV_REF  = 6'b010000;
  localparam logic [5:0] EV_DONE = 6'b100000;
  localparam int B_ACT = 0, B_RD = 1, B_WR = 2, B_PRE = 3, B_REF = 4;

  logic [5:0] ev_now;
  assign ev_now = {ref_done, ref_req, pre_req, wr_req, rd_req, act_req};

  sal_bank_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ra(req_ra), .req_ca(req_ca), .req_id(req_id), .req_len(req_len),
    .ref_in(ref_in), .ref_done(ref_done),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .ra(ra), .ca(ca), .id(id), .len(len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_gnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected event: which output rises, how many cycles after the last accept
  // or grant edge it first becomes visible, and the row address shown then.
  typedef struct {
    logic [5:0] ev;
    int         dly;
    bit         from_gnt;
    dram_ra_t   ra;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every newly raised request or ref_done pulse is matched in order.
  logic [5:0] ev_prev = '0;
  always @(negedge clk) begin
    logic [5:0] rise;
    exp_t e;
    int d;
    rise = ev_now & ~ev_prev;
    ev_prev = ev_now;
    if ($countones(ev_now[4:0]) > 1) begin
      errors++;
      $display("FAIL onehot: got %b required at most one request", ev_now[4:0]);
    end
    if (rise != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %b at cycle %0d required none", rise, cyc);
      end else begin
        e = exp_q.pop_front();
        d = cyc - (e.from_gnt ? last_gnt : last_acc);
        if (rise !== e.ev || d != e.dly || ra !== e.ra) begin
          errors++;
          $display("FAIL event: got ev=%b dly=%0d ra=%h required ev=%b dly=%0d ra=%h",
                   rise, d, ra, e.ev, e.dly, e.ra);
        end
      end
    end
  end

  // A grant must only ever answer a raised request.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ((gnt & ~ev_now[4:0]) == '0)
      else begin
        errors++;
        $display("FAIL grant_without_req: gnt=%b req=%b", gnt, ev_now[4:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic expect_ev(input logic [5:0] ev, input int dly, input bit from_gnt, input dram_ra_t r);
    exp_t e;
    e.ev = ev; e.dly = dly; e.from_gnt = from_gnt; e.ra = r;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic w, input dram_ra_t r, input dram_ca_t c, input axi_id_t i, input axi_len_t l);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready=0 required 1");
      return;
    end
    req_wr = w; req_ra = r; req_ca = c; req_id = i; req_len = l;
    req_valid = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_ev(input int b, output bit ok);
    int n;
    n = 0;
    while (!ev_now[b] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = ev_now[b];
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_req%0d: got 0 required 1 within 200 cycles", b);
    end
  endtask

  task automatic grant(input int b);
    bit ok;
    wait_ev(b, ok);
    if (ok) begin
      gnt[b] = 1'b1;
      @(posedge clk); #1;
      last_gnt = cyc;
      gnt = '0;
    end
  endtask

  initial begin
    bit ok;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqs", {58'd0, ev_now}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_latch", {26'd0, ra, ca, id, len}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // 1: read to closed bank, tRCD after ACT grant.
    expect_ev(EV_ACT, 0, 1'b0, 16'h0012);
    expect_ev(EV_RD, 4, 1'b1, 16'h0012);
    send(1'b0, 16'h0012, 10'h011, 4'h1, 8'h03);
    grant(B_ACT);
    wait_ev(B_RD, ok);
    chk("ready_busy", {63'd0, req_ready}, 64'd0);
    grant(B_RD);
    chk("ready_after_rd", {63'd0, req_ready}, 64'd1);

    // 2: row hit, column command right after accept.
    expect_ev(EV_RD, 0, 1'b0, 16'h0012);
    send(1'b0, 16'h0012, 10'h022, 4'h2, 8'h00);
    grant(B_RD);

    // 3: write then row miss; precharge waits out write-to-precharge.
    expect_ev(EV_WR, 0, 1'b0, 16'h0012);
    send(1'b1, 16'h0012, 10'h033, 4'h3, 8'h07);
    grant(B_WR);
    expect_ev(EV_PRE, 10, 1'b1, 16'h0034);
    expect_ev(EV_ACT, 4, 1'b1, 16'h0034);
    expect_ev(EV_RD, 4, 1'b1, 16'h0034);
    send(1'b0, 16'h0034, 10'h044, 4'h4, 8'h01);
    grant(B_PRE);
    grant(B_ACT);
    chk("act_row", {48'd0, ra}, 64'h34);
    grant(B_RD);

    // 4: refresh beats a pending row-hit read.
    expect_ev(EV_PRE, 7, 1'b1, 16'h0034);
    expect_ev(EV_REF, 4, 1'b1, 16'h0034);
    expect_ev(EV_DONE, 43, 1'b1, 16'h0034);
    expect_ev(EV_ACT, 44, 1'b1, 16'h0034);
    expect_ev(EV_RD, 4, 1'b1, 16'h0034);
    req_wr = 1'b0; req_ra = 16'h0034; req_ca = 10'h055; req_id = 4'h5; req_len = 8'h02;
    req_valid = 1'b1;
    ref_in = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    req_valid = 1'b0;
    ref_in = 1'b0;
    grant(B_PRE);
    grant(B_REF);
    grant(B_ACT);
    grant(B_RD);

    // 5: grant stall keeps request and latched fields steady.
    expect_ev(EV_RD, 0, 1'b0, 16'h0034);
    send(1'b0, 16'h0034, 10'h2ab, 4'hc, 8'h5a);
    wait_ev(B_RD, ok);
    for (int i = 0; i < 20; i++) begin
      chk("stall", {24'd0, rd_req, req_ready, ra, ca, id, len},
          {24'd0, 1'b1, 1'b0, 16'h0034, 10'h2ab, 4'hc, 8'h5a});
      @(posedge clk); #1;
    end
    grant(B_RD);

    // 6: reset while open mid-tRAS drops everything.
    expect_ev(EV_PRE, 3, 1'b1, 16'h0056);
    expect_ev(EV_ACT, 4, 1'b1, 16'h0056);
    expect_ev(EV_RD, 4, 1'b1, 16'h0056);
    send(1'b0, 16'h0056, 10'h066, 4'h6, 8'h04);
    grant(B_PRE);
    grant(B_ACT);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_reqs", {58'd0, ev_now}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd0);
    chk("midrst_latch", {26'd0, ra, ca, id, len}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_midrst", {63'd0, req_ready}, 64'd1);
    expect_ev(EV_ACT, 0, 1'b0, 16'h0078);
    expect_ev(EV_RD, 4, 1'b1, 16'h0078);
    send(1'b0, 16'h0078, 10'h077, 4'h7, 8'h00);
    grant(B_ACT);
    grant(B_RD);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
